// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter and sequencer for a single-port memory with timeout abort.
module mem_arbiter #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  input  logic                  req0_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [WIDTH-1:0]      req0_wdata_i,
  output logic                  req0_ready_o,
  output logic                  req0_rvalid_o,
  output logic [WIDTH-1:0]      req0_rdata_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [WIDTH-1:0]      req1_wdata_i,
  output logic                  req1_ready_o,
  output logic                  req1_rvalid_o,
  output logic [WIDTH-1:0]      req1_rdata_o,
  output logic                  err_o,
  output logic                  err_id_o,
  output logic                  busy_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                  state_q, state_d;
  logic                    ptr_q, ptr_d, id_q, id_d, wr_q, wr_d, win;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              ready_q, ready_d, rvalid_q, rvalid_d;
  logic [1:0][WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d, err_id_q, err_id_d;
  logic                    busy_q, busy_d, mem_valid_q, mem_valid_d;
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ready_d  = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    err_id_d = err_id_q;
    win      = (req0_valid_i && req1_valid_i) ? ptr_q : req1_valid_i;
    case (state_q)
      IDLE: if (req0_valid_i || req1_valid_i) begin
        state_d = BUSY;
        id_d    = win;
        wr_d    = win ? req1_wr_rd_i : req0_wr_rd_i;
        addr_d  = win ? req1_addr_i : req0_addr_i;
        wdata_d = win ? req1_wdata_i : req0_wdata_i;
        cnt_d   = '0;
      end
      BUSY: if (mem_ready_i) begin
        state_d        = DONE;
        ready_d[id_q]  = 1'b1;
        if (!wr_q) begin
          rvalid_d[id_q] = 1'b1;
          rdata_d[id_q]  = mem_rdata_i;
        end
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d       = DONE;
        ready_d[id_q] = 1'b1;
        err_d         = 1'b1;
        err_id_d      = id_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = ~id_q;
      end
      default: state_d = IDLE;
    endcase
    mem_valid_d = state_d == BUSY;
    busy_d      = state_d != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      ready_q     <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_id_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_id_q    <= err_id_d;
      busy_q      <= busy_d;
      mem_valid_q <= mem_valid_d;
    end
  end
  assign req0_ready_o  = ready_q[0];
  assign req1_ready_o  = ready_q[1];
  assign req0_rvalid_o = rvalid_q[0];
  assign req1_rvalid_o = rvalid_q[1];
  assign req0_rdata_o  = rdata_q[0];
  assign req1_rdata_o  = rdata_q[1];
  assign err_o         = err_q;
  assign err_id_o      = err_id_q;
  assign busy_o        = busy_q;
  assign mem_valid_o   = mem_valid_q;
  assign mem_wr_rd_o   = wr_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory model.
module tb_mem_arbiter;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        req0_valid_i = 1'b0, req0_wr_rd_i = 1'b0, req1_valid_i = 1'b0, req1_wr_rd_i = 1'b0;
  logic [3:0]  req0_addr_i = '0, req1_addr_i = '0;
  logic [15:0] req0_wdata_i = '0, req1_wdata_i = '0;
  logic        req0_ready_o, req0_rvalid_o, req1_ready_o, req1_rvalid_o;
  logic [15:0] req0_rdata_o, req1_rdata_o;
  logic        err_o, err_id_o, busy_o, mem_valid_o, mem_wr_rd_o, mem_ready_i;
  logic [3:0]  mem_addr_o;
  logic [15:0] mem_wdata_o, mem_rdata_i;
  logic        stall = 1'b0;
  logic [15:0] mem [16];
  logic [15:0] ref_mem [16];
  logic [15:0] exp_rd [2];
  int tests = 0, fails = 0, cyc = 0, vcnt = 0;
  typedef struct packed {logic id; logic err; logic rv; logic [15:0] rd;} exp_t;
  exp_t q[$];

  mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_wr_rd_i(req0_wr_rd_i), .req0_addr_i(req0_addr_i),
    .req0_wdata_i(req0_wdata_i), .req0_ready_o(req0_ready_o), .req0_rvalid_o(req0_rvalid_o),
    .req0_rdata_o(req0_rdata_o),
    .req1_valid_i(req1_valid_i), .req1_wr_rd_i(req1_wr_rd_i), .req1_addr_i(req1_addr_i),
    .req1_wdata_i(req1_wdata_i), .req1_ready_o(req1_ready_o), .req1_rvalid_o(req1_rvalid_o),
    .req1_rdata_o(req1_rdata_o),
    .err_o(err_o), .err_id_o(err_id_o), .busy_o(busy_o),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;
  assign mem_ready_i = mem_valid_o & ~stall;
  assign mem_rdata_i = mem[mem_addr_o];
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_valid_o && mem_ready_i && mem_wr_rd_o) mem[mem_addr_o] <= mem_wdata_o;
  end

  // Monitor: pops one expectation per completion pulse and checks invariants every cycle.
  always @(negedge clk_i) if (!rst_i) begin
    if (mem_valid_o) vcnt++;
    tests++;
    if (mem_valid_o && !busy_o) begin fails++; $display("FAIL mem_valid_outside_busy got=1 exp=0"); end
    tests++;
    if (err_o && !(req0_ready_o || req1_ready_o)) begin fails++; $display("FAIL err_without_ready got=1 exp=0"); end
    if (req0_ready_o || req1_ready_o) begin
      exp_t e;
      logic [4:0] got, want;
      tests++;
      if (req0_ready_o && req1_ready_o) begin fails++; $display("FAIL double_ready got=11 exp=one-hot"); end
      else if (q.size() == 0) begin fails++; $display("FAIL unexpected_ready r0=%0b r1=%0b exp=none", req0_ready_o, req1_ready_o); end
      else begin
        e = q.pop_front();
        got  = {req1_ready_o, err_o, err_o ? err_id_o : 1'b0, req0_rvalid_o, req1_rvalid_o};
        want = {e.id, e.err, e.err ? e.id : 1'b0, e.rv && !e.id, e.rv && e.id};
        if (got !== want) begin fails++; $display("FAIL completion {id,err,err_id,rv0,rv1} got=%b exp=%b", got, want); end
        tests++;
        if ((e.id ? req1_rdata_o : req0_rdata_o) !== e.rd) begin
          fails++;
          $display("FAIL rdata%0d got=%h exp=%h", e.id, e.id ? req1_rdata_o : req0_rdata_o, e.rd);
        end
      end
    end
  end

  task automatic expect_txn(input bit id, input bit wr, input logic [3:0] a, input logic [15:0] wd, input bit err);
    if (!err && wr) ref_mem[a] = wd;
    if (!err && !wr) exp_rd[id] = ref_mem[a];
    q.push_back('{id: id, err: err, rv: !err && !wr, rd: exp_rd[id]});
  endtask

  task automatic drive(input bit id, input bit wr, input logic [3:0] a, input logic [15:0] wd, output int t);
    int n = 0;
    logic rdy;
    if (id) begin req1_valid_i = 1; req1_wr_rd_i = wr; req1_addr_i = a; req1_wdata_i = wd; end
    else    begin req0_valid_i = 1; req0_wr_rd_i = wr; req0_addr_i = a; req0_wdata_i = wd; end
    do begin
      @(negedge clk_i);
      n++;
      rdy = id ? req1_ready_o : req0_ready_o;
    end while (!rdy && n < 100);
    t = cyc;
    if (!rdy) begin tests++; fails++; $display("FAIL ready_timeout req%0d got=0 exp=1", id); end
    @(posedge clk_i);
    #1;
    if (id) req1_valid_i = 0; else req0_valid_i = 0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1 rst_i = 1;
    @(posedge clk_i); #1 rst_i = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic check_zero(input string name);
    logic [79:0] v;
    @(negedge clk_i);
    v = {req0_ready_o, req0_rvalid_o, req0_rdata_o, req1_ready_o, req1_rvalid_o, req1_rdata_o,
         err_o, err_id_o, busy_o, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o};
    tests++;
    if (v !== '0) begin fails++; $display("FAIL %s outputs got=%h exp=0", name, v); end
  endtask

  initial begin
    int t0, t1, t2, t3, v0;
    for (int i = 0; i < 16; i++) begin mem[i] = 16'h1000 + 16'(i); ref_mem[i] = 16'h1000 + 16'(i); end
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    check_zero("reset");
    @(posedge clk_i); #1;
    expect_txn(0, 1, 4'd3, 16'hABCD, 0); drive(0, 1, 4'd3, 16'hABCD, t0);
    expect_txn(0, 0, 4'd3, 16'h0000, 0); drive(0, 0, 4'd3, 16'h0000, t0);
    do_reset();
    check_zero("reset2");
    @(posedge clk_i); #1;
    expect_txn(0, 0, 4'd1, 16'h0, 0);
    expect_txn(1, 0, 4'd2, 16'h0, 0);
    fork drive(0, 0, 4'd1, 16'h0, t0); drive(1, 0, 4'd2, 16'h0, t1); join
    tests++;
    if (!(t0 < t1)) begin fails++; $display("FAIL pair1_order t0=%0d t1=%0d exp=t0<t1", t0, t1); end
    expect_txn(0, 1, 4'd7, 16'h1234, 0); drive(0, 1, 4'd7, 16'h1234, t0);
    expect_txn(1, 0, 4'd3, 16'h0, 0);
    expect_txn(0, 0, 4'd7, 16'h0, 0);
    fork drive(0, 0, 4'd7, 16'h0, t0); drive(1, 0, 4'd3, 16'h0, t1); join
    tests++;
    if (!(t1 < t0)) begin fails++; $display("FAIL pair2_order t0=%0d t1=%0d exp=t1<t0", t0, t1); end
    do_reset();
    expect_txn(1, 0, 4'd1, 16'h0, 0); drive(1, 0, 4'd1, 16'h0, t1);
    expect_txn(1, 0, 4'd2, 16'h0, 0); drive(1, 0, 4'd2, 16'h0, t2);
    expect_txn(1, 0, 4'd3, 16'h0, 0); drive(1, 0, 4'd3, 16'h0, t3);
    tests++;
    if (t2 - t1 != 3) begin fails++; $display("FAIL req1_gap1 got=%0d exp=3", t2 - t1); end
    tests++;
    if (t3 - t2 != 3) begin fails++; $display("FAIL req1_gap2 got=%0d exp=3", t3 - t2); end
    stall = 1;
    v0 = vcnt;
    expect_txn(1, 0, 4'd5, 16'h0, 1); drive(1, 0, 4'd5, 16'h0, t0);
    tests++;
    if (vcnt - v0 != 8) begin fails++; $display("FAIL timeout_valid_cycles got=%0d exp=8", vcnt - v0); end
    req0_wr_rd_i = 0; req0_addr_i = 4'd4; req0_valid_i = 1;
    @(posedge clk_i); #1;
    rst_i = 1; req0_valid_i = 0;
    @(posedge clk_i); #1 rst_i = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    check_zero("mid_reset");
    stall = 0;
    @(posedge clk_i); #1;
    expect_txn(0, 0, 4'd4, 16'h0, 0); drive(0, 0, 4'd4, 16'h0, t0);
    expect_txn(1, 1, 4'd15, 16'hFFFF, 0); drive(1, 1, 4'd15, 16'hFFFF, t0);
    expect_txn(1, 0, 4'd15, 16'hFFFF, 0); drive(1, 0, 4'd15, 16'hFFFF, t0);
    expect_txn(1, 0, 4'd0, 16'hFFFF, 0); drive(1, 0, 4'd0, 16'hFFFF, t0);
    repeat (4) @(negedge clk_i);
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL pending_expectations got=%0d exp=0", q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
